// File: rtl/control_unit.sv
// Decode/control stage of a single-issue RV32I core with an integrated 32x32 register file.
// Optional REG_BYPASS_EN: write-through forwarding of write_data to same-cycle rs1/rs2 reads.
module control_unit (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] instruction_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] write_data,
    output logic [3:0]  aluControl_o,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic        branch_en,
    output logic [19:0] pc_imm
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    logic [31:0] rf [0:31];

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [19:0] b_off;
    logic [19:0] j_off;
    logic        writes_rd;
    logic        rf_we;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        br_take;

    assign opcode = instruction_i[6:0];
    assign rd     = instruction_i[11:7];
    assign funct3 = instruction_i[14:12];
    assign rs1    = instruction_i[19:15];
    assign rs2    = instruction_i[24:20];
    assign imm_i  = {{20{instruction_i[31]}}, instruction_i[31:20]};
    assign imm_s  = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
    assign imm_u  = {instruction_i[31:12], 12'b0};
    assign b_off  = {{8{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                     instruction_i[30:25], instruction_i[11:8]};
    assign j_off  = {instruction_i[31], instruction_i[19:12], instruction_i[20],
                     instruction_i[30:21]};

    assign writes_rd = (opcode == OPC_OP)  || (opcode == OPC_OP_IMM) || (opcode == OPC_LOAD) ||
                       (opcode == OPC_JAL) || (opcode == OPC_LUI)    || (opcode == OPC_AUIPC);
    assign rf_we     = writes_rd && !reset_i && (rd != 5'd0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (rf_we) begin
            rf[rd] <= write_data;
        end
    end

    // x0 is hardwired by the read mux; its storage slot is never written after reset
    always_comb begin
        rs1_val = rf[rs1];
        rs2_val = rf[rs2];
`ifdef REG_BYPASS_EN
        if (rf_we && (rd == rs1)) rs1_val = write_data;
        if (rf_we && (rd == rs2)) rs2_val = write_data;
`endif
        if (rs1 == 5'd0) rs1_val = '0;
        if (rs2 == 5'd0) rs2_val = '0;
    end

    always_comb begin
        br_take = 1'b0;
        case (funct3)
            3'b000:  br_take = (rs1_val == rs2_val);
            3'b001:  br_take = (rs1_val != rs2_val);
            3'b100:  br_take = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_take = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_take = (rs1_val <  rs2_val);
            3'b111:  br_take = (rs1_val >= rs2_val);
            default: br_take = 1'b0;
        endcase
    end

    always_comb begin
        aluControl_o = ALU_ADD;
        op1          = '0;
        op2          = '0;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        branch_en    = 1'b0;
        pc_imm       = '0;
        case (opcode)
            OPC_OP: begin
                aluControl_o = {instruction_i[30], funct3};
                op1          = rs1_val;
                op2          = rs2_val;
            end
            OPC_OP_IMM: begin
                // bit30 is part of the immediate except for the shift-right pair
                aluControl_o = {(funct3 == 3'b101) ? instruction_i[30] : 1'b0, funct3};
                op1          = rs1_val;
                op2          = imm_i;
            end
            OPC_LOAD: begin
                op1      = rs1_val;
                op2      = imm_i;
                mem_en   = 1'b1;
                mem_addr = rs1_val + imm_i;
            end
            OPC_STORE: begin
                op1      = rs1_val;
                op2      = rs2_val;
                mem_en   = 1'b1;
                mem_wr   = 1'b1;
                mem_addr = rs1_val + imm_s;
            end
            OPC_LUI: begin
                op2 = imm_u;
            end
            OPC_AUIPC: begin
                op1 = pc_i;
                op2 = imm_u;
            end
            OPC_JAL: begin
                op1       = pc_i;
                op2       = 32'd4;
                branch_en = 1'b1;
                pc_imm    = j_off;
            end
            OPC_BRANCH: begin
                aluControl_o = ALU_SUB;
                op1          = rs1_val;
                op2          = rs2_val;
                branch_en    = br_take;
                pc_imm       = b_off;
            end
            default: ;
        endcase
        if (reset_i) begin
            mem_en    = 1'b0;
            mem_wr    = 1'b0;
            branch_en = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected decode results are queued as each
// instruction is driven and popped for comparison once the outputs have settled.
module tb_control_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] instruction_i;
    logic [31:0] pc_i;
    logic [31:0] write_data;
    logic [3:0]  aluControl_o;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        mem_en;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic        branch_en;
    logic [19:0] pc_imm;

    typedef struct packed {
        logic [3:0]  alu;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        me;
        logic        mw;
        logic [31:0] ma;
        logic        br;
        logic [19:0] pi;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    control_unit dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .instruction_i(instruction_i),
        .pc_i         (pc_i),
        .write_data   (write_data),
        .aluControl_o (aluControl_o),
        .op1          (op1),
        .op2          (op2),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .branch_en    (branch_en),
        .pc_imm       (pc_imm)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_head();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".alu"},       {28'd0, aluControl_o}, {28'd0, e.alu});
        check({t, ".op1"},       op1,                   e.op1);
        check({t, ".op2"},       op2,                   e.op2);
        check({t, ".mem_en"},    {31'd0, mem_en},       {31'd0, e.me});
        check({t, ".mem_wr"},    {31'd0, mem_wr},       {31'd0, e.mw});
        check({t, ".mem_addr"},  mem_addr,              e.ma);
        check({t, ".branch_en"}, {31'd0, branch_en},    {31'd0, e.br});
        check({t, ".pc_imm"},    {12'd0, pc_imm},       {12'd0, e.pi});
    endtask

    // Called right after a rising edge; the register write lands on the following edge.
    task automatic step(input string tag, input logic rst, input logic [31:0] ins,
                        input logic [31:0] pc, input logic [31:0] wd,
                        input logic [3:0] alu, input logic [31:0] e1, input logic [31:0] e2,
                        input logic me, input logic mw, input logic [31:0] ma,
                        input logic br, input logic [19:0] pi);
        exp_t e;
        #1;
        reset_i       = rst;
        instruction_i = ins;
        pc_i          = pc;
        write_data    = wd;
        e = '{alu: alu, op1: e1, op2: e2, me: me, mw: mw, ma: ma, br: br, pi: pi};
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #3;
        compare_head();
        @(posedge clk_i);
    endtask

    initial begin
        logic [31:0] byp_a1;
`ifdef REG_BYPASS_EN
        byp_a1 = 32'd6;
`else
        byp_a1 = 32'd5;
`endif
        reset_i       = 1'b1;
        instruction_i = 32'h0000_0013;
        pc_i          = '0;
        write_data    = '0;
        repeat (2) @(posedge clk_i);

        step("rst_beq",   1, 32'h00B58463, 0,     0,     4'b1000, 0,     0,     0, 0, 0, 0, 20'h00004);
        step("jal_p100",  0, 32'h0640056F, 20,    24,    4'b0000, 20,    4,     0, 0, 0, 1, 20'h00032);
        step("jal_m100",  0, 32'hF9DFF56F, 200,   204,   4'b0000, 200,   4,     0, 0, 0, 1, 20'hFFFCE);
        step("addi_a1",   0, 32'h00500593, 0,     5,     4'b0000, 0,     5,     0, 0, 0, 0, 20'h0);
        step("addi_a0",   0, 32'h02258513, 0,     39,    4'b0000, 5,     34,    0, 0, 0, 0, 20'h0);
        step("addi_a2",   0, 32'h00300613, 0,     3,     4'b0000, 0,     3,     0, 0, 0, 0, 20'h0);
        step("sub",       0, 32'h40C58533, 0,     2,     4'b1000, 5,     3,     0, 0, 0, 0, 20'h0);
        step("wr_x0",     0, 32'h00100013, 0,     32'hDEAD, 4'b0000, 0,  1,     0, 0, 0, 0, 20'h0);
        step("rd_x0",     0, 32'h00000513, 0,     0,     4'b0000, 0,     0,     0, 0, 0, 0, 20'h0);
        step("beq_t",     0, 32'h00B58463, 0,     0,     4'b1000, 5,     5,     0, 0, 0, 1, 20'h00004);
        step("bne_t",     0, 32'h00C59463, 0,     0,     4'b1000, 5,     3,     0, 0, 0, 1, 20'h00004);
        step("beq_nt",    0, 32'h00C58463, 0,     0,     4'b1000, 5,     3,     0, 0, 0, 0, 20'h00004);
        step("addi_m1",   0, 32'hFFF00693, 0,     32'hFFFFFFFF, 4'b0000, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 20'h0);
        step("blt",       0, 32'h00B6C463, 0,     0,     4'b1000, 32'hFFFFFFFF, 5, 0, 0, 0, 1, 20'h00004);
        step("bge",       0, 32'h00B6D463, 0,     0,     4'b1000, 32'hFFFFFFFF, 5, 0, 0, 0, 0, 20'h00004);
        step("bltu",      0, 32'h00B6E463, 0,     0,     4'b1000, 32'hFFFFFFFF, 5, 0, 0, 0, 0, 20'h00004);
        step("bgeu",      0, 32'h00B6F463, 0,     0,     4'b1000, 32'hFFFFFFFF, 5, 0, 0, 0, 1, 20'h00004);
        step("br_f3_010", 0, 32'h00B6A463, 0,     0,     4'b1000, 32'hFFFFFFFF, 5, 0, 0, 0, 0, 20'h00004);
        step("xor",       0, 32'h00C5C733, 0,     6,     4'b0100, 5,     3,     0, 0, 0, 0, 20'h0);
        step("srai",      0, 32'h4046D793, 0,     32'hFFFFFFFF, 4'b1101, 32'hFFFFFFFF, 32'h404, 0, 0, 0, 0, 20'h0);
        step("addi_neg",  0, 32'hC0058513, 0,     32'hFFFFFC05, 4'b0000, 5, 32'hFFFFFC00, 0, 0, 0, 0, 20'h0);
        step("lw",        0, 32'h0085A803, 0,     32'h77, 4'b0000, 5,    8,     1, 0, 13, 0, 20'h0);
        step("sw",        0, 32'hFEC5AE23, 0,     32'h1234, 4'b0000, 5,  3,     1, 1, 1, 0, 20'h0);
        step("lui",       0, 32'h123458B7, 0,     32'h12345000, 4'b0000, 0, 32'h12345000, 0, 0, 0, 0, 20'h0);
        step("auipc",     0, 32'h00001297, 32'h100, 32'h1100, 4'b0000, 32'h100, 32'h1000, 0, 0, 0, 0, 20'h0);
        step("jalr_nop",  0, 32'h000580E7, 32'h40, 32'hBAD, 4'b0000, 0,  0,     0, 0, 0, 0, 20'h0);
        step("no_wr",     0, 32'h001E0533, 0,     0,     4'b0000, 0,     0,     0, 0, 0, 0, 20'h0);
        step("add_ld",    0, 32'h00580533, 0,     5,     4'b0000, 32'h77, 32'h1100, 0, 0, 0, 0, 20'h0);
        step("or",        0, 32'h00E8E533, 0,     0,     4'b0110, 32'h12345000, 6, 0, 0, 0, 0, 20'h0);
        step("bypass",    0, 32'h00158593, 0,     6,     4'b0000, byp_a1, 1,    0, 0, 0, 0, 20'h0);
        step("rst_lw",    1, 32'h0085A803, 0,     32'h99, 4'b0000, 6,    8,     0, 0, 14, 0, 20'h0);
        step("rst_beq2",  1, 32'h00B58463, 0,     0,     4'b1000, 0,     0,     0, 0, 0, 0, 20'h00004);
        step("post_rst",  0, 32'h01058533, 0,     0,     4'b0000, 0,     0,     0, 0, 0, 0, 20'h0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
